switch_egress_arb: RTL and testbench
====================================

SWITCH_EGRESS_ARB -- requirements
Module: switch_egress_arb

Interface
REQ-001 Parameter: NUM_OF_PORTS, 4, number of switch output ports drained.
REQ-002 Parameter: WORD_WIDTH, 8, data word width.
REQ-003 Parameter: EGR_FIFO_DEPTH, 16, egress buffer depth in words (power of 2, at least 4).
REQ-004 Parameter: RD_TIMEOUT, 8, maximum cycles from grant to first read_out before abort.
REQ-005 Port: clk  in  1  single clock; all logic on the rising edge.
REQ-006 Port: rst  in  1  asynchronous, active-high reset.
REQ-007 Port: port_ready  in  NUM_OF_PORTS  per-port "packet available" from the switch.
REQ-008 Port: read_out  in  1  switch "data valid" on the granted port.
REQ-009 Port: port_out  in  NUM_OF_PORTS*WORD_WIDTH  concatenated port data; port i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-010 Port: port_read  out  NUM_OF_PORTS  one-hot read request to the switch.
REQ-011 Port: egr_valid / egr_ready  out / in  1 / 1  egress stream handshake.
REQ-012 Port: egr_data  out  WORD_WIDTH  egress word.
REQ-013 Port: egr_sop, egr_eop  out  1 each  first and last word of a packet.
REQ-014 Port: egr_port  out  $clog2(NUM_OF_PORTS)  source port of the current word.
REQ-015 Port: timeout_err  out  1  one-cycle pulse on a grant abort.

Function
REQ-016 The FSM SHALL have the states IDLE, GRANT, WAIT, XFER and FLUSH.
- IDLE -> GRANT when the FIFO is empty and any port_ready bit is 1.
- GRANT -> WAIT unconditionally.
- WAIT -> XFER when read_out=1.
- WAIT -> IDLE after RD_TIMEOUT cycles without read_out.
- XFER -> FLUSH when read_out=0.
- FLUSH -> IDLE.
REQ-017 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_OF_PORTS, and the pointer advances only on a grant.
REQ-018 In GRANT, port_read SHALL be one-hot on the winner for exactly one cycle; it SHALL be 0 in all other states.
REQ-019 Each cycle with read_out=1 in WAIT or XFER SHALL capture the granted port's word into a stage register.
- The previously staged word, if any, SHALL be pushed with last=0.
REQ-020 In FLUSH, the staged word SHALL be pushed with last=1, so a packet of N words yields N FIFO entries.
REQ-021 The first pushed word of each packet SHALL carry sop=1.
- A 1-word packet SHALL carry sop=1 and eop=1.
REQ-022 Each FIFO entry SHALL hold {sop, last, port, data}.
- egr_* SHALL reflect the head entry.
- egr_valid=1 whenever the FIFO is not empty.
REQ-023 A pop SHALL occur only on egr_valid && egr_ready.
- egr_* SHALL be held stable while egr_valid=1 and egr_ready=0.
REQ-024 A packet longer than EGR_FIFO_DEPTH words SHALL have its excess words dropped.
- The final pushed entry SHALL still carry eop=1, overwriting the tail-slot eop.
REQ-025 Simultaneous push and pop at full SHALL succeed.
- Simultaneous push and pop at empty SHALL push only.
REQ-026 In a timeout abort, timeout_err SHALL pulse in the cycle of the WAIT -> IDLE transition, and no entry SHALL be pushed.
REQ-027 read_out=1 in IDLE or GRANT SHALL be ignored.

Reset
REQ-028 On rst, the block SHALL enter IDLE with all of the following:
- FIFO empty; stage register empty.
- Round-robin pointer such that port 0 wins first.
- port_read=0, egr_valid=0, egr_sop=0, egr_eop=0, egr_data=0, egr_port=0, timeout_err=0.
REQ-029 A reset mid-packet SHALL discard all buffered words.
- After release, no eop SHALL be emitted for the discarded packet.

Configuration
REQ-030 Macro EGR_PKT_CNT_EN SHALL control the per-port packet counters.
- When defined: the output pkt_cnt, NUM_OF_PORTS*16 bits, SHALL exist, with one 16-bit wrapping counter per port.
- A port's counter SHALL increment on each popped word with eop=1 from that port, and SHALL reset to 0.
- When undefined: the port and the counters SHALL be absent; all other behaviour is identical.

Verification
REQ-031 port_ready=4'b0100; port 2 returns read_out for 3 cycles with 0x11, 0x22, 0x33; egr_ready=1 -> port_read=4'b0100 for one cycle; egress 0x11(sop), 0x22, 0x33(eop), all with egr_port=2.
REQ-032 port_ready=4'b1111 held, 1-word packets -> grant order 0, 1, 2, 3, 0.
REQ-033 Grant with no read_out for 8 cycles -> timeout_err pulses once, no egress, and the next grant goes to the next port.
REQ-034 A 20-word packet with egr_ready=0 -> FIFO holds 16 entries and the last entry has eop=1; after egr_ready=1, exactly 16 words are output.
REQ-035 egr_ready toggles every cycle during a 5-word packet -> data stable while stalled, with no loss or duplication.
REQ-036 rst asserted mid-XFER -> all outputs at reset values immediately; after release, the next packet starts with sop=1 and has the correct length.

Source files
------------

// File: rtl/switch_egress_arb.sv
// Round-robin drain of switch output ports into a buffered egress word stream.
// Defining EGR_PKT_CNT_EN adds per-port counters of popped end-of-packet words.
module switch_egress_arb #(
  parameter int  NUM_OF_PORTS   = 4,
  parameter int  WORD_WIDTH     = 8,
  parameter int  EGR_FIFO_DEPTH = 16,
  parameter int  RD_TIMEOUT     = 8,
  localparam int PW             = (NUM_OF_PORTS > 1) ? $clog2(NUM_OF_PORTS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_OF_PORTS-1:0]            port_ready,
  input  logic                               read_out,
  input  logic [NUM_OF_PORTS*WORD_WIDTH-1:0] port_out,
  output logic [NUM_OF_PORTS-1:0]            port_read,
  output logic                               egr_valid,
  input  logic                               egr_ready,
  output logic [WORD_WIDTH-1:0]              egr_data,
  output logic                               egr_sop,
  output logic                               egr_eop,
  output logic [PW-1:0]                      egr_port,
  output logic                               timeout_err
`ifdef EGR_PKT_CNT_EN
  , output logic [NUM_OF_PORTS*16-1:0]       pkt_cnt
`endif
);

  localparam int AW = $clog2(EGR_FIFO_DEPTH);
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, GRANT, WAIT, XFER, FLUSH} state_t;

  typedef struct packed {
    logic                  sop;
    logic                  last;
    logic [PW-1:0]         port;
    logic [WORD_WIDTH-1:0] data;
  } entry_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         last_grant, grant_port, winner, cand;
  logic                  winner_found;
  logic [TW-1:0]         wait_cnt;
  logic [WORD_WIDTH-1:0] stage_data;
  logic                  stage_valid, first_word, capture;
  logic [WORD_WIDTH-1:0] lanes [NUM_OF_PORTS];

  entry_t                mem [EGR_FIFO_DEPTH];
  entry_t                head, push_entry;
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [AW-1:0]         tail_idx;
  logic                  fifo_empty, fifo_full, pop, push_req, push_ok, mark_tail;

  for (genvar p = 0; p < NUM_OF_PORTS; p++) begin : g_lane
    assign lanes[p] = port_out[p*WORD_WIDTH +: WORD_WIDTH];
  end

  // Search starts one past the last winner and wraps at NUM_OF_PORTS.
  always_comb begin
    winner       = last_grant;
    winner_found = 1'b0;
    cand         = last_grant;
    for (int i = 0; i < NUM_OF_PORTS; i++) begin
      cand = (cand == PW'(NUM_OF_PORTS - 1)) ? '0 : cand + 1'b1;
      if (!winner_found && port_ready[cand]) begin
        winner       = cand;
        winner_found = 1'b1;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
  always_comb begin
    state_nxt   = state;
    port_read   = '0;
    timeout_err = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE:  if (fifo_empty && winner_found) state_nxt = GRANT;
      GRANT: begin
        port_read[grant_port] = 1'b1;
        state_nxt             = WAIT;
      end
      WAIT: begin
        if (read_out) begin
          capture   = 1'b1;
          state_nxt = XFER;
        end else if (wait_cnt == TW'(RD_TIMEOUT - 1)) begin
          timeout_err = 1'b1;
          state_nxt   = IDLE;
        end
      end
      XFER: begin
        if (read_out) capture = 1'b1;
        else          state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= PW'(NUM_OF_PORTS - 1);
      grant_port  <= '0;
      wait_cnt    <= '0;
      stage_data  <= '0;
      stage_valid <= 1'b0;
      first_word  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (state == IDLE && state_nxt == GRANT) begin
        grant_port <= winner;
        last_grant <= winner;
        first_word <= 1'b1;
      end else if (push_req) begin
        first_word <= 1'b0;
      end
      if (capture) begin
        stage_data  <= lanes[grant_port];
        stage_valid <= 1'b1;
      end else if (state == FLUSH) begin
        stage_valid <= 1'b0;
      end
    end
  end

  // The staged word is pushed one capture late, so FLUSH always carries the last word.
  assign push_req   = stage_valid && (capture || state == FLUSH);
  assign push_entry = '{sop: first_word, last: (state == FLUSH), port: grant_port, data: stage_data};

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop        = !fifo_empty && egr_ready;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign mark_tail  = push_req && push_entry.last && fifo_full && !pop;
  assign tail_idx   = wr_ptr[AW-1:0] - 1'b1;

  // NOTE: the storage array has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok)        mem[wr_ptr[AW-1:0]] <= push_entry;
    else if (mark_tail) mem[tail_idx].last  <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign egr_valid = !fifo_empty;
  assign egr_data  = egr_valid ? head.data : '0;
  assign egr_sop   = egr_valid && head.sop;
  assign egr_eop   = egr_valid && head.last;
  assign egr_port  = egr_valid ? head.port : '0;

`ifdef EGR_PKT_CNT_EN
  logic [15:0] cnt [NUM_OF_PORTS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OF_PORTS; i++) cnt[i] <= '0;
    end else if (pop && head.last) begin
      cnt[head.port] <= cnt[head.port] + 16'd1;
    end
  end

  for (genvar p = 0; p < NUM_OF_PORTS; p++) begin : g_cnt
    assign pkt_cnt[p*16 +: 16] = cnt[p];
  end
`endif

endmodule

// File: tb/tb_switch_egress_arb.sv
// Directed bench for switch_egress_arb: a packet-level expected-word queue checked on every pop,
// plus hand-computed grant orders, timeout latency and egress word literals.
`timescale 1ns/1ps
module tb_switch_egress_arb;

  localparam int NP = 4;
  localparam int WW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     port_ready;
  logic              read_out;
  logic [NP*WW-1:0]  port_out;
  logic [NP-1:0]     port_read;
  logic              egr_valid, egr_ready;
  logic [WW-1:0]     egr_data;
  logic              egr_sop, egr_eop;
  logic [1:0]        egr_port;
  logic              timeout_err;

  switch_egress_arb #(
    .NUM_OF_PORTS(NP), .WORD_WIDTH(WW), .EGR_FIFO_DEPTH(16), .RD_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .port_ready(port_ready), .read_out(read_out), .port_out(port_out),
    .port_read(port_read), .egr_valid(egr_valid), .egr_ready(egr_ready), .egr_data(egr_data),
    .egr_sop(egr_sop), .egr_eop(egr_eop), .egr_port(egr_port), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         sop;
    bit         eop;
    int         port;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        pop_log[$];
  ent_t        cur;
  int          checks = 0;
  int          errors = 0;
  int          pr_cycles = 0;
  int          tmo_pulses = 0;
  logic        prev_stall;
  logic [11:0] prev_out;
  logic [NP-1:0] prev_pr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] pack(input ent_t e);
    return {e.sop, e.eop, e.port[1:0], e.data};
  endfunction

  function automatic int oh_idx(input logic [NP-1:0] v);
    for (int i = 0; i < NP; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Compare process: samples mid-cycle, pops the expected queue on every handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
      prev_pr    <= '0;
    end else begin
      check("port_read_onehot", ($countones(port_read) <= 1), 1);
      if (port_read != 0) begin
        pr_cycles <= pr_cycles + 1;
        check("port_read_single_cycle", prev_pr, 0);
      end
      if (timeout_err) tmo_pulses <= tmo_pulses + 1;
      if (prev_stall) begin
        check("stall_valid", egr_valid, 1);
        check("stall_stable", {egr_sop, egr_eop, egr_port, egr_data}, prev_out);
      end
      if (egr_valid && egr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", exp_q.size(), 1);
        end else begin
          cur = exp_q.pop_front();
          check("egr_data", egr_data, cur.data);
          check("egr_sop", egr_sop, cur.sop);
          check("egr_eop", egr_eop, cur.eop);
          check("egr_port", egr_port, cur.port);
        end
        pop_log.push_back('{data: egr_data, sop: egr_sop, eop: egr_eop, port: int'(egr_port)});
      end
      prev_stall <= egr_valid && !egr_ready;
      prev_out   <= {egr_sop, egr_eop, egr_port, egr_data};
      prev_pr    <= port_read;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input int port, input logic [7:0] w);
    for (int i = 0; i < NP; i++) port_out[i*WW +: WW] = (i == port) ? w : ~w;
  endtask

  task automatic wait_grant(output int gport);
    int n = 0;
    while (port_read == 0 && n < 200) begin
      cyc();
      n++;
    end
    check("grant_seen", (port_read != 0), 1);
    gport = oh_idx(port_read);
  endtask

  // Word k of a packet is base + 17*k; only the first `keep` words reach egress.
  task automatic do_pkt(input int n_words, input int keep, input logic [7:0] base,
                        input logic [NP-1:0] ready_after, input bit ro_in_grant, output int gport);
    wait_grant(gport);
    port_ready = ready_after;
    for (int k = 0; k < keep; k++)
      exp_q.push_back('{data: 8'(base + 17*k), sop: (k == 0), eop: (k == keep-1), port: gport});
    if (ro_in_grant) begin
      read_out = 1'b1;
      drive_word(gport, 8'hEE);
    end
    cyc();
    for (int k = 0; k < n_words; k++) begin
      read_out = 1'b1;
      drive_word(gport, 8'(base + 17*k));
      cyc();
    end
    read_out = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || egr_valid) && n < 300) begin
      cyc();
      n++;
    end
    check(name, exp_q.size(), 0);
    check({name, "_valid"}, egr_valid, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_port_read"}, port_read, 0);
    check({name, "_valid"}, egr_valid, 0);
    check({name, "_sop"}, egr_sop, 0);
    check({name, "_eop"}, egr_eop, 0);
    check({name, "_data"}, egr_data, 0);
    check({name, "_port"}, egr_port, 0);
    check({name, "_timeout"}, timeout_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, base, pr0, tp0, t, eops;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [11:0] t1_exp[3] = '{12'hA11, 12'h222, 12'h633};

    rst = 1'b1; port_ready = '0; read_out = 1'b0; port_out = '0; egr_ready = 1'b0;
    cyc(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    cyc();

    // read_out while idle is ignored
    read_out = 1'b1; drive_word(0, 8'h5A);
    cyc(3);
    read_out = 1'b0;
    cyc(3);
    check("idle_ignore_valid", egr_valid, 0);

    // Single 3-word packet from port 2
    egr_ready = 1'b1; port_ready = 4'b0100;
    pr0 = pr_cycles; base = pop_log.size();
    do_pkt(3, 3, 8'h11, 4'b0000, 1'b0, g);
    check("t1_grant", g, 2);
    wait_drain("t1_drain");
    check("t1_port_read_cycles", pr_cycles - pr0, 1);
    check("t1_pops", pop_log.size() - base, 3);
    if (pop_log.size() >= base + 3)
      for (int i = 0; i < 3; i++) check("t1_word", pack(pop_log[base+i]), t1_exp[i]);

    // Round-robin over held requests after reset
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    port_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      do_pkt(1, 1, 8'(8'h40 + i), (i == 4) ? 4'b0000 : 4'b1111, 1'b0, g);
      check("t2_grant_order", g, order[i]);
    end
    wait_drain("t2_drain");
    if (pop_log.size() > 0) check("t2_last_word", pack(pop_log[pop_log.size()-1]), 12'hC44);

    // Grant timeout, then the next port wins
    port_ready = 4'b1111;
    tp0 = tmo_pulses; base = pop_log.size();
    wait_grant(g);
    check("t3_grant", g, 1);
    port_ready = 4'b0000;
    t = 0;
    while (!timeout_err && t < 30) begin
      cyc();
      t++;
    end
    check("t3_timeout_latency", t, 8);
    cyc(20);
    check("t3_timeout_pulses", tmo_pulses - tp0, 1);
    check("t3_no_egress", pop_log.size() - base, 0);
    check("t3_valid", egr_valid, 0);
    port_ready = 4'b1111;
    do_pkt(2, 2, 8'h70, 4'b0000, 1'b1, g);
    check("t3_next_grant", g, 2);
    wait_drain("t3_drain");

    // 20-word packet into a stalled 16-deep buffer
    egr_ready = 1'b0; port_ready = 4'b1000;
    do_pkt(20, 16, 8'h03, 4'b0000, 1'b0, g);
    check("t4_grant", g, 3);
    cyc(5);
    check("t4_valid_held", egr_valid, 1);
    check("t4_head", {egr_sop, egr_eop, egr_port, egr_data}, 12'hB03);
    base = pop_log.size();
    egr_ready = 1'b1;
    wait_drain("t4_drain");
    check("t4_pops", pop_log.size() - base, 16);
    if (pop_log.size() > 0) check("t4_last_word", pack(pop_log[pop_log.size()-1]), 12'h702);
    eops = 0;
    for (int i = base; i < pop_log.size(); i++) eops += int'(pop_log[i].eop);
    check("t4_eop_count", eops, 1);

    // egr_ready toggles every cycle during a 5-word packet
    port_ready = 4'b0001; base = pop_log.size();
    fork
      do_pkt(5, 5, 8'hA0, 4'b0000, 1'b0, g);
      begin
        repeat (40) begin
          egr_ready = ~egr_ready;
          cyc();
        end
      end
    join
    egr_ready = 1'b1;
    wait_drain("t5_drain");
    check("t5_grant", g, 0);
    check("t5_pops", pop_log.size() - base, 5);

    // Reset in the middle of a transfer
    egr_ready = 1'b0; port_ready = 4'b0010;
    wait_grant(g);
    check("t6_grant", g, 1);
    port_ready = 4'b0000;
    cyc();
    for (int k = 0; k < 3; k++) begin
      read_out = 1'b1;
      drive_word(1, 8'(8'h90 + k));
      cyc();
    end
    rst = 1'b1; read_out = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    cyc(2);
    rst = 1'b0;
    cyc();
    egr_ready = 1'b1; port_ready = 4'b0001; base = pop_log.size();
    do_pkt(4, 4, 8'hC0, 4'b0000, 1'b0, g);
    check("t6_post_grant", g, 0);
    wait_drain("t6_drain");
    check("t6_pops", pop_log.size() - base, 4);
    if (pop_log.size() >= base + 4) begin
      check("t6_first_word", pack(pop_log[base]), 12'h8C0);
      check("t6_last_word", pack(pop_log[base+3]), 12'h4F3);
    end
    eops = 0;
    for (int i = base; i < pop_log.size(); i++) eops += int'(pop_log[i].eop);
    check("t6_eop_count", eops, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
